digpot_step_ctrl: RTL

DIGPOT_STEP_CTRL -- requirements
Module: digpot_step_ctrl

---
 rtl/digpot_step_ctrl_if.sv | 24 ++
 rtl/digpot_step_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/digpot_step_ctrl_if.sv
// Request handshake and pot-pin bundle for digpot_step_ctrl.
// master: the requester side (drives req_valid/req_pos, observes the pot pins and status).
// slave:  the controller side.
interface digpot_step_ctrl_if;
  logic       req_valid;
  logic [6:0] req_pos;
  logic       req_ready;
  logic       cs_n;
  logic       inc_n;
  logic       ud;
  logic [6:0] cur_pos;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_pos,
    input  req_ready, cs_n, inc_n, ud, cur_pos, busy, done
  );

  modport slave (
    input  req_valid, req_pos,
    output req_ready, cs_n, inc_n, ud, cur_pos, busy, done
  );
endinterface

// File: rtl/digpot_step_ctrl.sv
// Up/down digital potentiometer step controller (CS/INC/UD three-wire pots).
// Homes the wiper to 0 after reset, then steps it to requested positions.
// Every pot-pin phase lasts K+1 clk cycles.
// Build option: define DIGPOT_STORE_EN to deselect with inc_n high so the pot
// stores the wiper to NVM; the deselect phase is then doubled for store time.
module digpot_step_ctrl #(
  parameter logic [25:0] K     = 26'd499,
  parameter int unsigned STEPS = 100
) (
  input logic          clk,
  input logic          rst,
  digpot_step_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StHome, StIdle, StSetup, StLow, StHigh, StDesel} state_e;

  localparam logic [6:0] MaxPos = 7'(STEPS - 1);

  state_e      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [6:0]  steps_q, steps_d;
  logic [6:0]  cur_pos_q, cur_pos_d;
  logic        ud_q, ud_d;
  logic        homing_q, homing_d;
  logic        done_q, done_d;
`ifdef DIGPOT_STORE_EN
  logic        desel2_q, desel2_d;
`endif

  logic       tick;
  logic       step_now;
  logic [6:0] clamped;

  assign tick    = (cnt_q == K);
  assign clamped = (bus.req_pos > MaxPos) ? MaxPos : bus.req_pos;

  // State and datapath registers; reset aborts any move and restarts homing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHome;
      cnt_q     <= '0;
      steps_q   <= '0;
      cur_pos_q <= '0;
      ud_q      <= 1'b0;
      homing_q  <= 1'b1;
      done_q    <= 1'b0;
`ifdef DIGPOT_STORE_EN
      desel2_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      cur_pos_q <= cur_pos_d;
      ud_q      <= ud_d;
      homing_q  <= homing_d;
      done_q    <= done_d;
`ifdef DIGPOT_STORE_EN
      desel2_q  <= desel2_d;
`endif
    end
  end

  // Next-state logic; ud only moves in IDLE/HOME so it is stable while selected.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q == StIdle || tick) ? 26'd0 : cnt_q + 26'd1;
    steps_d   = steps_q;
    cur_pos_d = cur_pos_q;
    ud_d      = ud_q;
    homing_d  = homing_q;
    done_d    = 1'b0;
    step_now  = 1'b0;
`ifdef DIGPOT_STORE_EN
    desel2_d  = desel2_q;
`endif
    unique case (state_q)
      StHome: begin
        steps_d  = MaxPos;
        ud_d     = 1'b0;
        homing_d = 1'b1;
        if (tick) state_d = StSetup;
      end
      StIdle: begin
        if (bus.req_valid) begin
          homing_d = 1'b0;
          if (clamped == cur_pos_q) begin
            done_d = 1'b1;
          end else begin
            ud_d    = (clamped > cur_pos_q);
            steps_d = (clamped > cur_pos_q) ? clamped - cur_pos_q : cur_pos_q - clamped;
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        if (tick) begin
          state_d  = StLow;
          step_now = 1'b1;
        end
      end
      StLow: begin
        if (tick) state_d = StHigh;
      end
      StHigh: begin
        if (tick) begin
          if (steps_q != 7'd0) begin
            state_d  = StLow;
            step_now = 1'b1;
          end else begin
            state_d = StDesel;
          end
        end
      end
      StDesel: begin
        if (tick) begin
`ifdef DIGPOT_STORE_EN
          if (!desel2_q) begin
            desel2_d = 1'b1;
          end else begin
            desel2_d = 1'b0;
            state_d  = StIdle;
            done_d   = 1'b1;
          end
`else
          state_d = StIdle;
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = StHome;
    endcase

    // Wiper moves on the inc_n falling edge, i.e. on entry to LOW.
    if (step_now) begin
      if (steps_q != 7'd0) steps_d = steps_q - 7'd1;
      if (!homing_q) begin
        if (ud_q) begin
          if (cur_pos_q < MaxPos) cur_pos_d = cur_pos_q + 7'd1;
        end else begin
          if (cur_pos_q != 7'd0) cur_pos_d = cur_pos_q - 7'd1;
        end
      end
    end
  end

  // Pot pins and status decoded from state so reset forces them immediately.
  always_comb begin
    bus.cs_n      = 1'b1;
    bus.inc_n     = 1'b1;
    bus.req_ready = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.ud        = ud_q;
    bus.cur_pos   = cur_pos_q;
    bus.done      = done_q;
    unique case (state_q)
      StSetup: bus.cs_n = 1'b0;
      StLow: begin
        bus.cs_n  = 1'b0;
        bus.inc_n = 1'b0;
      end
      StHigh: bus.cs_n = 1'b0;
`ifdef DIGPOT_STORE_EN
      StDesel: bus.inc_n = 1'b1;
`else
      StDesel: bus.inc_n = 1'b0;  // cs_n rises with inc_n low: no NVM store
`endif
      default: ;
    endcase
  end

endmodule
